uart_tx: RTL and testbench

- Transmit half of the UART; pairs with the existing receiver on the same baud/clock parameters.
- Accepts bytes over a valid/ready handshake and serialises them on tx as 8N1 (or 8N2) frames, LSB first.
- Contains its own baud divider and a one-byte holding register, so back-to-back bytes go out with no idle gap.
- Sits between the command/response logic and the board TX pin.

---
 rtl/uart_tx.sv | 163 ++++++++++++++++
 tb/tb_uart_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing, LSB first.
// Includes a baud divider and a one-byte holding register so frames go out back to back.
module uart_tx #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 38400000,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic SB_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx;
  logic [2:0]    idx_d;
  logic          sb;
  logic          sb_d;
  logic [7:0]    shift;
  logic [7:0]    shift_d;
  logic [7:0]    hold;
  logic [7:0]    hold_d;
  logic          hold_full;
  logic          hold_full_d;
  logic          tx_d;

  logic clr;
  logic accept;
  logic tick;
  logic stop_end;
  logic load_direct;

  assign clr      = rst | soft_reset;
  assign ready    = ~hold_full;
  assign accept   = valid & ready;
  assign tick     = (cnt == LAST);
  assign stop_end = (state == STOP) & tick & (sb == SB_LAST);
  assign busy     = (state != IDLE) | hold_full;

  // A byte bypasses the holding register when the shifter is free:
  // in IDLE, or on the final stop cycle with nothing held.
  assign load_direct = accept & ((state == IDLE) | (stop_end & ~hold_full));

  // State, datapath and line register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sb        <= 1'b0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      sb        <= sb_d;
      shift     <= shift_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
      tx        <= tx_d;
    end
  end

  // Next-state, baud/bit counting and holding-register control.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    sb_d        = sb;
    shift_d     = shift;
    hold_d      = hold;
    hold_full_d = hold_full;

    if (state != IDLE) begin
      cnt_d = tick ? '0 : cnt + CW'(1);
    end

    if (accept && !load_direct) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          shift_d = data;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == 3'd7) begin
            sb_d    = 1'b0;
            state_d = STOP;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sb == SB_LAST) begin
            if (hold_full) begin
              shift_d     = hold;
              hold_full_d = 1'b0;
              state_d     = START;
            end else if (accept) begin
              shift_d = data;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sb_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the state being entered, so tx lines up with it.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[idx_d];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=16, one and two stop bits.
// Expected line levels come from hand-built frame tables.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       soft_reset;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;

  logic       soft_reset2;
  logic [7:0] data2;
  logic       valid2;
  logic       ready2;
  logic       tx2;
  logic       busy2;

  int n_checks;
  int n_errors;

  uart_tx #(
    .BAUD_RATE(1),
    .CLOCK_FREQ(16),
    .STOP_BITS(1)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .soft_reset(soft_reset),
    .data(data),
    .valid(valid),
    .ready(ready),
    .tx(tx),
    .busy(busy)
  );

  uart_tx #(
    .BAUD_RATE(1),
    .CLOCK_FREQ(16),
    .STOP_BITS(2)
  ) u_dut2 (
    .clk(clk),
    .rst(rst),
    .soft_reset(soft_reset2),
    .data(data2),
    .valid(valid2),
    .ready(ready2),
    .tx(tx2),
    .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line level k cycles after the accepting edge, 16 cycles per bit.
  function automatic logic exp_bit(input int k, input logic [7:0] b);
    int p;
    p = k / 16;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    return 1'b1;
  endfunction

  logic [7:0] rx_byte;
  logic       rx_stop;
  logic [7:0] lb [3];
  int         wait_n;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    soft_reset  = 1'b0;
    soft_reset2 = 1'b0;
    data        = 8'h00;
    valid       = 1'b0;
    data2       = 8'h00;
    valid2      = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset", {29'd0, tx, busy, ready}, 32'h5);
    check("reset2", {29'd0, tx2, busy2, ready2}, 32'h5);

    // Single 0xA5 frame
    data  = 8'hA5;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int k = 0; k < 160; k++) begin
      check($sformatf("a5 k=%0d", k), {29'd0, tx, busy, ready},
            {29'd0, exp_bit(k, 8'hA5), 1'b1, 1'b1});
      step();
    end
    check("a5 end", {29'd0, tx, busy, ready}, 32'h5);

    // Back-to-back 0x00 then 0xFF with valid held
    data  = 8'h00;
    valid = 1'b1;
    step();
    data = 8'hFF;
    for (int k = 0; k < 320; k++) begin
      if (k == 1) valid = 1'b0;
      check($sformatf("b2b k=%0d", k), {29'd0, tx, busy, ready},
            {29'd0, (k < 160) ? exp_bit(k, 8'h00) : exp_bit(k - 160, 8'hFF),
             1'b1, (k == 0) || (k >= 160)});
      step();
    end
    check("b2b end", {29'd0, tx, busy, ready}, 32'h5);

    // Two stop bits, 0x55
    data2  = 8'h55;
    valid2 = 1'b1;
    step();
    valid2 = 1'b0;
    for (int k = 0; k < 176; k++) begin
      check($sformatf("sb2 k=%0d", k), {30'd0, tx2, busy2},
            {30'd0, exp_bit(k, 8'h55), 1'b1});
      step();
    end
    check("sb2 end", {29'd0, tx2, busy2, ready2}, 32'h5);

    // soft_reset during data bit 3 with a byte held
    data  = 8'h3C;
    valid = 1'b1;
    step();
    data = 8'h99;
    step();
    valid = 1'b0;
    check("sr held", {31'd0, ready}, 32'h0);
    for (int k = 1; k < 70; k++) step();
    check("sr bit3", {31'd0, tx}, 32'h1);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    check("sr after", {29'd0, tx, busy, ready}, 32'h5);
    for (int k = 0; k < 200; k++) begin
      check($sformatf("sr idle k=%0d", k), {30'd0, tx, busy}, 32'h2);
      step();
    end

    // rst wins over a same-cycle accept
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h81;
    step();
    rst   = 1'b0;
    valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      check($sformatf("rstv k=%0d", k), {29'd0, tx, busy, ready}, 32'h5);
      step();
    end

    // Loopback into a mid-bit sampling receiver
    lb[0] = 8'h00;
    lb[1] = 8'h7E;
    lb[2] = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      data  = lb[n];
      valid = 1'b1;
      step();
      valid  = 1'b0;
      wait_n = 0;
      while (tx !== 1'b0 && wait_n < 40) begin
        step();
        wait_n++;
      end
      check($sformatf("lb start %0d", n), {31'd0, tx}, 32'h0);
      for (int i = 0; i < 8; i++) step();
      check($sformatf("lb mid %0d", n), {31'd0, tx}, 32'h0);
      for (int b = 0; b < 8; b++) begin
        for (int i = 0; i < 16; i++) step();
        rx_byte[b] = tx;
      end
      for (int i = 0; i < 16; i++) step();
      rx_stop = tx;
      check($sformatf("lb data %0d", n), {24'd0, rx_byte}, {24'd0, lb[n]});
      check($sformatf("lb stop %0d", n), {31'd0, rx_stop}, 32'h1);
      wait_n = 0;
      while (busy !== 1'b0 && wait_n < 40) begin
        step();
        wait_n++;
      end
      check($sformatf("lb idle %0d", n), {31'd0, busy}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
